eth_rx_dest_filter: RTL and testbench



---
 rtl/eth_rx_filter_pkg.sv | 41 ++++
 rtl/eth_rx_filter_ram.sv | 32 +++
 rtl/eth_rx_dest_filter.sv | 211 +++++++++++++++++++++
 tb/tb_eth_rx_dest_filter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eth_rx_filter_pkg.sv
// eth_rx_filter_pkg: shared types and constants for the RX destination filter.
//   state_t    - frame FSM states (IDLE, HDR, PASS, DROP)
//   entry_t    - one buffer entry {data, last, user}
//   BCAST_ADDR - broadcast destination address
//   HDR_LEN    - bytes buffered before the filter decision
//   da_accept  - destination-address accept rule
package eth_rx_filter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PASS,
    DROP
  } state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic       user;
  } entry_t;

  localparam logic [47:0] BCAST_ADDR = 48'hFFFF_FFFF_FFFF;
  localparam int unsigned HDR_LEN    = 6;

  // Bit 40 is the group bit: LSB of the first byte on the wire.
  function automatic logic da_accept(
    input logic [47:0] da,
    input logic [47:0] local_mac,
    input logic        promisc,
    input logic        accept_bcast,
    input logic        accept_mcast
  );
    logic is_bcast;
    is_bcast = (da == BCAST_ADDR);
    return promisc
         | (da == local_mac)
         | (is_bcast & accept_bcast)
         | (da[40] & ~is_bcast & accept_mcast);
  endfunction

endpackage

// File: rtl/eth_rx_filter_ram.sv
// eth_rx_filter_ram: simple dual-port distributed RAM, synchronous write,
// asynchronous read, no reset.
//   clk   - write clock
//   we    - write enable
//   waddr - write address
//   wdata - write entry
//   raddr - read address
//   rdata - read entry (combinational)
module eth_rx_filter_ram
  import eth_rx_filter_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  entry_t                   wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output entry_t                   rdata
);

  entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/eth_rx_dest_filter.sv
// eth_rx_dest_filter: receive-path destination MAC filter. Buffers the first
// 6 bytes of each frame, then forwards or discards the whole frame. The MAC
// side never stalls; runts and buffer overflow are absorbed here.
//   clk, rst                 - receive clock, synchronous active-high reset
//   s_axis_*                 - MAC byte stream (no tready)
//   m_axis_*                 - registered byte stream to the RX FIFO
//   cfg_*                    - station address and accept rules
//   stat_*                   - frame counters
// Build option: define ETH_RX_FILTER_STATS_EN to implement the counters;
// otherwise stat_* are tied to zero.
module eth_rx_dest_filter
  import eth_rx_filter_pkg::*;
#(
  parameter int unsigned BUF_DEPTH   = 16,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             s_axis_tdata,
  input  logic                   s_axis_tvalid,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tuser,
  output logic [7:0]             m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  input  logic [47:0]            cfg_local_mac,
  input  logic                   cfg_promisc,
  input  logic                   cfg_accept_bcast,
  input  logic                   cfg_accept_mcast,
  output logic [COUNT_WIDTH-1:0] stat_accept,
  output logic [COUNT_WIDTH-1:0] stat_drop_filter,
  output logic [COUNT_WIDTH-1:0] stat_runt,
  output logic [COUNT_WIDTH-1:0] stat_overflow
);

  localparam int unsigned AW = $clog2(BUF_DEPTH);
  typedef logic [AW-1:0] ptr_t;

  state_t      state;
  ptr_t        wr_ptr, commit_ptr, commit_d, rd_ptr;
  logic [2:0]  hdr_cnt;
  logic [39:0] hdr_q;
  logic        out_valid;
  entry_t      out_entry;

  logic   fire, at_limit, is_dec, hit;
  ptr_t   rd_next, occ;
  logic   wr_en;
  entry_t wr_entry, rd_entry;
  logic   ev_runt, ev_ovf, ev_accept, ev_reject;

  assign fire     = out_valid & m_axis_tready;
  assign rd_next  = rd_ptr + ptr_t'(fire);
  // Occupancy is taken after this cycle's read.
  assign occ      = wr_ptr - rd_ptr - ptr_t'(fire);
  // Stop normal writes one short of the limit so the terminator always fits.
  assign at_limit = (occ >= ptr_t'(BUF_DEPTH - 2));
  assign is_dec   = (hdr_cnt == 3'(HDR_LEN - 1));
  assign hit      = da_accept({hdr_q, s_axis_tdata}, cfg_local_mac, cfg_promisc,
                              cfg_accept_bcast, cfg_accept_mcast);

  always_comb begin
    wr_en     = 1'b0;
    wr_entry  = '{data: s_axis_tdata, last: s_axis_tlast, user: s_axis_tuser};
    ev_runt   = 1'b0;
    ev_ovf    = 1'b0;
    ev_accept = 1'b0;
    ev_reject = 1'b0;
    if (s_axis_tvalid) begin
      case (state)
        IDLE: begin
          if (s_axis_tlast)  ev_runt = 1'b1;
          else if (at_limit) ev_ovf  = 1'b1;
          else               wr_en   = 1'b1;
        end
        HDR: begin
          if (s_axis_tlast && !is_dec) ev_runt = 1'b1;
          else if (at_limit)           ev_ovf  = 1'b1;
          else begin
            wr_en = 1'b1;
            if (is_dec) begin
              ev_accept = hit;
              ev_reject = ~hit;
            end
          end
        end
        PASS: begin
          wr_en = 1'b1;
          if (at_limit) begin
            ev_ovf   = 1'b1;
            wr_entry = '{data: 8'h00, last: 1'b1, user: 1'b1};
          end
        end
        default: ;
      endcase
    end
  end

  eth_rx_filter_ram #(.DEPTH(BUF_DEPTH)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_entry),
    .raddr (rd_next),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      commit_d   <= '0;
      rd_ptr     <= '0;
      hdr_cnt    <= '0;
      hdr_q      <= '0;
      out_valid  <= 1'b0;
      out_entry  <= '0;
    end else begin
      // Read side sees commits one cycle late, giving the 7-cycle first-byte latency.
      commit_d <= commit_ptr;
      rd_ptr   <= rd_next;
      if (!out_valid || m_axis_tready) begin
        out_valid <= (rd_next != commit_d);
        out_entry <= (rd_next != commit_d) ? rd_entry : '0;
      end

      if (s_axis_tvalid && (state == IDLE || state == HDR)) begin
        hdr_q <= {hdr_q[31:0], s_axis_tdata};
      end

      if (s_axis_tvalid) begin
        case (state)
          IDLE: begin
            if (ev_ovf) begin
              state <= DROP;
            end else if (!ev_runt) begin
              wr_ptr  <= wr_ptr + ptr_t'(1);
              hdr_cnt <= 3'd1;
              state   <= HDR;
            end
          end
          HDR: begin
            if (ev_runt) begin
              wr_ptr <= commit_ptr;
              state  <= IDLE;
            end else if (ev_ovf || ev_reject) begin
              wr_ptr <= commit_ptr;
              state  <= s_axis_tlast ? IDLE : DROP;
            end else if (ev_accept) begin
              wr_ptr     <= wr_ptr + ptr_t'(1);
              commit_ptr <= wr_ptr + ptr_t'(1);
              state      <= s_axis_tlast ? IDLE : PASS;
            end else begin
              wr_ptr  <= wr_ptr + ptr_t'(1);
              hdr_cnt <= hdr_cnt + 3'd1;
            end
          end
          PASS: begin
            wr_ptr     <= wr_ptr + ptr_t'(1);
            commit_ptr <= wr_ptr + ptr_t'(1);
            if (s_axis_tlast)  state <= IDLE;
            else if (ev_ovf)   state <= DROP;
          end
          DROP: begin
            if (s_axis_tlast) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign m_axis_tvalid = out_valid;
  assign m_axis_tdata  = out_entry.data;
  assign m_axis_tlast  = out_entry.last;
  assign m_axis_tuser  = out_entry.user;

`ifdef ETH_RX_FILTER_STATS_EN
  logic [COUNT_WIDTH-1:0] acc_q, drop_q, runt_q, ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      drop_q <= '0;
      runt_q <= '0;
      ovf_q  <= '0;
    end else begin
      // An overflow in PASS retracts the accept counted at the decision beat.
      if (ev_accept)                    acc_q <= acc_q + COUNT_WIDTH'(1);
      else if (ev_ovf && state == PASS) acc_q <= acc_q - COUNT_WIDTH'(1);
      if (ev_reject) drop_q <= drop_q + COUNT_WIDTH'(1);
      if (ev_runt)   runt_q <= runt_q + COUNT_WIDTH'(1);
      if (ev_ovf)    ovf_q  <= ovf_q + COUNT_WIDTH'(1);
    end
  end

  assign stat_accept      = acc_q;
  assign stat_drop_filter = drop_q;
  assign stat_runt        = runt_q;
  assign stat_overflow    = ovf_q;
`else
  assign stat_accept      = '0;
  assign stat_drop_filter = '0;
  assign stat_runt        = '0;
  assign stat_overflow    = '0;
`endif

endmodule

// File: tb/tb_eth_rx_dest_filter.sv
// tb_eth_rx_dest_filter: directed frames with hand-computed expected output
// pushed to a scoreboard queue; a negedge monitor pops and compares.
module tb_eth_rx_dest_filter;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } exp_t;

  localparam logic [47:0] LOCAL = 48'h02_11_22_33_44_55;
  localparam logic [47:0] OTHER = 48'h02_AA_BB_CC_DD_EE;
  localparam logic [47:0] MCAST = 48'h01_00_5E_00_00_01;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;

  logic        clk, rst;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tuser;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic [47:0] cfg_local_mac;
  logic        cfg_promisc, cfg_accept_bcast, cfg_accept_mcast;
  logic [31:0] stat_accept, stat_drop_filter, stat_runt, stat_overflow;

  eth_rx_dest_filter #(.BUF_DEPTH(16), .COUNT_WIDTH(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tvalid    (s_axis_tvalid),
    .s_axis_tlast     (s_axis_tlast),
    .s_axis_tuser     (s_axis_tuser),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .m_axis_tlast     (m_axis_tlast),
    .m_axis_tuser     (m_axis_tuser),
    .cfg_local_mac    (cfg_local_mac),
    .cfg_promisc      (cfg_promisc),
    .cfg_accept_bcast (cfg_accept_bcast),
    .cfg_accept_mcast (cfg_accept_mcast),
    .stat_accept      (stat_accept),
    .stat_drop_filter (stat_drop_filter),
    .stat_runt        (stat_runt),
    .stat_overflow    (stat_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  exp_t        sbq[$];
  int          errors = 0;
  int          checks = 0;
  bit          sb_ignore = 1'b0;
  bit          arm_lat = 1'b0;
  int unsigned byte0_edge = 0;
  int          ea = 0, ed = 0, er = 0, eo = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [63:0] sx(input int v);
`ifdef ETH_RX_FILTER_STATS_EN
    return 64'(v);
`else
    return (v == v) ? 64'd0 : 64'd0;
`endif
  endfunction

  task automatic check_stats(input string tag);
    chk({tag, "_stat_accept"},      64'(stat_accept),      sx(ea));
    chk({tag, "_stat_drop_filter"}, 64'(stat_drop_filter), sx(ed));
    chk({tag, "_stat_runt"},        64'(stat_runt),        sx(er));
    chk({tag, "_stat_overflow"},    64'(stat_overflow),    sx(eo));
  endtask

  function automatic logic [7:0] fbyte(input logic [47:0] da, input int i, input logic [7:0] seed);
    if (i < 6) return da[47-8*i -: 8];
    return seed + 8'(i);
  endfunction

  // Drives one frame starting at posedge+1; pushes the first n_exp bytes
  // (plus an overflow terminator if term) as expected output.
  task automatic send_frame(input logic [47:0] da, input int len, input logic [7:0] seed,
                            input bit user_last, input int n_exp, input bit term);
    exp_t e;
    for (int i = 0; i < n_exp; i++) begin
      e.d = fbyte(da, i, seed);
      e.l = (i == len - 1);
      e.u = user_last && (i == len - 1);
      sbq.push_back(e);
    end
    if (term) begin
      e.d = 8'h00; e.l = 1'b1; e.u = 1'b1;
      sbq.push_back(e);
    end
    for (int i = 0; i < len; i++) begin
      if (i == 0) byte0_edge = cyc + 1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = fbyte(da, i, seed);
      s_axis_tlast  = (i == len - 1);
      s_axis_tuser  = user_last && (i == len - 1);
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((sbq.size() != 0 || m_axis_tvalid) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 2000) begin
      errors++;
      $display("FAIL %s_drain: %0d bytes still expected after 2000 cycles, expected 0", tag, sbq.size());
    end
    repeat (5) begin @(posedge clk); #1; end
  endtask

  // Monitor: latency, hold-while-stalled and scoreboard comparison.
  logic       p_stall = 1'b0;
  logic [7:0] p_d;
  logic       p_l, p_u;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (arm_lat && m_axis_tvalid) begin
        arm_lat = 1'b0;
        chk("first_out_latency", 64'(cyc - byte0_edge), 64'd7);
      end
      if (p_stall) begin
        checks++;
        if (!(m_axis_tvalid && m_axis_tdata == p_d && m_axis_tlast == p_l && m_axis_tuser == p_u)) begin
          errors++;
          $display("FAIL hold_stable: got v=%0b d=%02h l=%0b u=%0b expected v=1 d=%02h l=%0b u=%0b",
                   m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, p_d, p_l, p_u);
        end
      end
      if (m_axis_tvalid && m_axis_tready && !sb_ignore) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got d=%02h l=%0b u=%0b expected no output",
                   m_axis_tdata, m_axis_tlast, m_axis_tuser);
        end else begin
          e = sbq.pop_front();
          if (m_axis_tdata !== e.d || m_axis_tlast !== e.l || m_axis_tuser !== e.u) begin
            errors++;
            $display("FAIL out_byte: got d=%02h l=%0b u=%0b expected d=%02h l=%0b u=%0b",
                     m_axis_tdata, m_axis_tlast, m_axis_tuser, e.d, e.l, e.u);
          end
        end
      end
    end
    p_stall = m_axis_tvalid && !m_axis_tready && !rst;
    p_d = m_axis_tdata;
    p_l = m_axis_tlast;
    p_u = m_axis_tuser;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
    m_axis_tready = 1'b1;
    cfg_local_mac = LOCAL;
    cfg_promisc = 1'b0; cfg_accept_bcast = 1'b1; cfg_accept_mcast = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("reset_tdata",  64'(m_axis_tdata),  64'd0);
    chk("reset_tlast",  64'(m_axis_tlast),  64'd0);
    chk("reset_tuser",  64'(m_axis_tuser),  64'd0);
    check_stats("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // 64-byte frame to the station address, first byte latency.
    arm_lat = 1'b1;
    send_frame(LOCAL, 64, 8'h10, 1'b0, 64, 1'b0);
    ea = 1;
    wait_drain("t1");
    chk("latency_seen", 64'(arm_lat), 64'd0);
    check_stats("t1");

    // Multicast dropped, broadcast passed, other unicast dropped.
    send_frame(MCAST, 20, 8'h20, 1'b0, 0, 1'b0);
    ed = 1;
    wait_drain("t2a");
    check_stats("t2_mcast");
    send_frame(BCAST, 20, 8'h30, 1'b0, 20, 1'b0);
    ea = 2;
    send_frame(OTHER, 20, 8'h40, 1'b0, 0, 1'b0);
    ed = 2;
    wait_drain("t2b");
    check_stats("t2_bcast");
    cfg_promisc = 1'b1;
    send_frame(MCAST, 20, 8'h50, 1'b0, 20, 1'b0);
    send_frame(BCAST, 20, 8'h60, 1'b0, 20, 1'b0);
    ea = 4;
    wait_drain("t2c");
    check_stats("t2_promisc");
    cfg_promisc = 1'b0;

    // Runt followed back-to-back by a good frame.
    send_frame(LOCAL, 4, 8'h70, 1'b0, 0, 1'b0);
    send_frame(LOCAL, 64, 8'h80, 1'b0, 64, 1'b0);
    er = 1; ea = 5;
    wait_drain("t3");
    check_stats("t3");

    // Overflow: 14 data bytes plus terminator, then a clean frame.
    m_axis_tready = 1'b0;
    send_frame(LOCAL, 200, 8'h90, 1'b0, 14, 1'b1);
    eo = 1;
    check_stats("t4_ovf");
    chk("t4_held_first_byte", 64'(m_axis_tdata), 64'h02);
    m_axis_tready = 1'b1;
    wait_drain("t4a");
    send_frame(LOCAL, 20, 8'hA0, 1'b0, 20, 1'b0);
    ea = 6;
    wait_drain("t4b");
    check_stats("t4");

    // tuser on the last byte is carried through.
    send_frame(LOCAL, 10, 8'hB0, 1'b1, 10, 1'b0);
    ea = 7;
    wait_drain("t5");
    check_stats("t5");

    // Reset in the middle of a passing frame.
    sb_ignore = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = fbyte(LOCAL, i, 8'hC0);
      s_axis_tlast  = 1'b0;
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_tvalid", 64'(m_axis_tvalid), 64'd0);
    chk("midrst_tdata",  64'(m_axis_tdata),  64'd0);
    chk("midrst_tlast",  64'(m_axis_tlast),  64'd0);
    chk("midrst_tuser",  64'(m_axis_tuser),  64'd0);
    ea = 0; ed = 0; er = 0; eo = 0;
    check_stats("midrst");
    rst = 1'b0;
    sbq.delete();
    @(posedge clk); #1;
    sb_ignore = 1'b0;
    send_frame(MCAST, 20, 8'hD0, 1'b0, 0, 1'b0);
    ed = 1;
    send_frame(LOCAL, 16, 8'hE0, 1'b0, 16, 1'b0);
    ea = 1;
    cfg_accept_mcast = 1'b1;
    send_frame(MCAST, 20, 8'hF0, 1'b0, 20, 1'b0);
    ea = 2;
    cfg_accept_bcast = 1'b0;
    send_frame(BCAST, 20, 8'h05, 1'b0, 0, 1'b0);
    ed = 2;
    wait_drain("t6");
    check_stats("t6");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
